// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - operand/result handshake bundle for serial_addsub
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial add/sub, DIGIT bits per clock from the LSB up
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_addsub: WIDTH must be at least 2");
    end
    if (DIGIT < 1) begin : g_bad_digit
      $error("serial_addsub: DIGIT must be at least 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
      $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    count;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT:0]   digit_sum;
  logic             carry_msb_in;
  logic             digit_ovf;
  logic [WIDTH-1:0] result_next;

  // On the last digit the low DIGIT bits of a_reg/b_reg hold the operand MSBs,
  // so the carry into the top bit is recovered from the digit sum itself.
  always_comb begin
    digit_sum    = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};
    carry_msb_in = digit_sum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
    digit_ovf    = carry_msb_in ^ digit_sum[DIGIT];
    result_next  = WIDTH'({digit_sum[DIGIT-1:0], result_r} >> DIGIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      result_r <= '0;
      count    <= '0;
      carry    <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg    <= bus.a;
            b_reg    <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            count    <= '0;
            result_r <= '0;
            state    <= S_ADD;
          end
        end
        S_ADD: begin
          a_reg    <= a_reg >> DIGIT;
          b_reg    <= b_reg >> DIGIT;
          carry    <= digit_sum[DIGIT];
          count    <= count + CW'(1);
          result_r <= result_next;
          if (count == LAST) begin
            cout_r <= digit_sum[DIGIT];
            ovf_r  <= digit_ovf;
`ifdef SERIAL_ADDSUB_SAT_EN
            // Overflow implies both operands share a sign; that sign picks the rail.
            if (digit_ovf) begin
              result_r <= {a_reg[DIGIT-1], {(WIDTH-1){~a_reg[DIGIT-1]}}};
            end
`endif
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state == S_ADD);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (8/1, 8/4 and 16/2 builds)
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails = 0;

  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(8))  if84 ();
  serial_addsub_if #(.WIDTH(16)) if16 ();

  // The DIGIT=4 unit sees exactly the same requests as the DIGIT=1 unit.
  assign if84.in_valid  = if8.in_valid;
  assign if84.a         = if8.a;
  assign if84.b         = if8.b;
  assign if84.sub       = if8.sub;
  assign if84.out_ready = if8.out_ready;

  serial_addsub #(.WIDTH(8),  .DIGIT(1)) d0 (.clk(clk), .rst(rst), .bus(if8));
  serial_addsub #(.WIDTH(8),  .DIGIT(4)) d1 (.clk(clk), .rst(rst), .bus(if84));
  serial_addsub #(.WIDTH(16), .DIGIT(2)) d2 (.clk(clk), .rst(rst), .bus(if16));

  always #5 clk = ~clk;

  function automatic void model(input int w, input longint ua, input longint ub, input bit s,
                                output longint r, output bit c, output bit v);
    longint m, h, sa, sb, t;
    m  = longint'(1) << w;
    h  = m >> 1;
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    t  = s ? sa - sb : sa + sb;
    c  = s ? (ua >= ub) : ((ua + ub) >= m);
    r  = (s ? ua - ub : ua + ub) & (m - 1);
    v  = (t > h - 1) || (t < -h);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (v) r = (t > 0) ? h - 1 : h;
`endif
  endfunction

  task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xs, input string tag);
    longint r;
    bit c, v;
    int lat0, lat1;
    model(8, longint'(xa), longint'(xb), xs, r, c, v);
    if8.a = xa; if8.b = xb; if8.sub = xs; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.sub = 1'($urandom);
    checks++;
    if (if8.busy !== 1'b1 || if8.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s accept: busy=%b in_ready=%b, required busy=1 in_ready=0", tag, if8.busy, if8.in_ready);
    end
    lat0 = 0; lat1 = 0;
    for (int n = 1; n <= 40 && (lat0 == 0 || lat1 == 0); n++) begin
      @(posedge clk); #1;
      if (lat0 == 0 && if8.out_valid === 1'b1) lat0 = n;
      if (lat1 == 0 && if84.out_valid === 1'b1) lat1 = n;
    end
    checks++;
    if (lat0 != 8) begin
      fails++;
      $display("FAIL %s latency d1: got %0d, required 8", tag, lat0);
    end
    checks++;
    if (lat1 != 2) begin
      fails++;
      $display("FAIL %s latency d4: got %0d, required 2", tag, lat1);
    end
    checks++;
    if ({if8.result, if8.cout, if8.ovf} !== {r[7:0], c, v}) begin
      fails++;
      $display("FAIL %s d1 result/cout/ovf: got %h/%b/%b, required %h/%b/%b", tag,
               if8.result, if8.cout, if8.ovf, r[7:0], c, v);
    end
    checks++;
    if ({if84.result, if84.cout, if84.ovf} !== {r[7:0], c, v}) begin
      fails++;
      $display("FAIL %s d4 result/cout/ovf: got %h/%b/%b, required %h/%b/%b", tag,
               if84.result, if84.cout, if84.ovf, r[7:0], c, v);
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    checks++;
    if (if8.in_ready !== 1'b1 || if84.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if84.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s release: in_ready=%b/%b out_valid=%b/%b, required 1/1 0/0", tag,
               if8.in_ready, if84.in_ready, if8.out_valid, if84.out_valid);
    end
  endtask

  task automatic op16(input logic [15:0] xa, input logic [15:0] xb, input logic xs, input string tag);
    longint r;
    bit c, v;
    int lat;
    model(16, longint'(xa), longint'(xb), xs, r, c, v);
    if16.a = xa; if16.b = xb; if16.sub = xs; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0; if16.a = 16'($urandom); if16.b = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (if16.out_valid === 1'b1) lat = n;
    end
    checks++;
    if (lat != 8) begin
      fails++;
      $display("FAIL %s latency: got %0d, required 8", tag, lat);
    end
    checks++;
    if ({if16.result, if16.cout, if16.ovf} !== {r[15:0], c, v}) begin
      fails++;
      $display("FAIL %s result/cout/ovf: got %h/%b/%b, required %h/%b/%b", tag,
               if16.result, if16.cout, if16.ovf, r[15:0], c, v);
    end
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if8.result, if8.cout, if8.ovf, if8.out_valid, if8.busy, if8.in_ready} !== {8'h00, 5'b00001} ||
        {if84.result, if84.cout, if84.ovf, if84.out_valid, if84.busy, if84.in_ready} !== {8'h00, 5'b00001} ||
        {if16.result, if16.cout, if16.ovf, if16.out_valid, if16.busy, if16.in_ready} !== {16'h0000, 5'b00001}) begin
      fails++;
      $display("FAIL reset state: d1 %h%b%b%b%b%b d4 %h%b%b%b%b%b d16 %h%b%b%b%b%b, required zeros with in_ready=1",
               if8.result, if8.cout, if8.ovf, if8.out_valid, if8.busy, if8.in_ready,
               if84.result, if84.cout, if84.ovf, if84.out_valid, if84.busy, if84.in_ready,
               if16.result, if16.cout, if16.ovf, if16.out_valid, if16.busy, if16.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub;
    op8(8'h5A, 8'h3C, 1'b0, "add_5a_3c");
    op8(8'h10, 8'h20, 1'b1, "sub_10_20");
    op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    op8(8'hAB, 8'h55, 1'b0, "add_ab_55");
    for (int k = 0; k < 16; k++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    end
  endtask

  task automatic test_overflow;
    op8(8'h7F, 8'h01, 1'b0, "ovf_add_7f_01");
    op8(8'h80, 8'h01, 1'b1, "ovf_sub_80_01");
    op8(8'h80, 8'h80, 1'b0, "ovf_add_80_80");
    op8(8'h00, 8'h80, 1'b1, "ovf_sub_00_80");
    op8(8'h33, 8'h00, 1'b1, "sub_zero");
  endtask

  task automatic test_backpressure;
    longint r;
    bit c, v;
    int lat;
    logic [7:0] xa, xb;
    xa = 8'($urandom); xb = 8'($urandom);
    model(8, longint'(xa), longint'(xb), 1'b0, r, c, v);
    if8.a = xa; if8.b = xb; if8.sub = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (if8.out_valid === 1'b1) lat = n;
    end
    checks++;
    if (lat != 8) begin
      fails++;
      $display("FAIL bp latency: got %0d, required 8", lat);
    end
    for (int i = 0; i < 5; i++) begin
      if8.in_valid = (i % 2 == 0);
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.sub = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 || {if8.result, if8.cout, if8.ovf} !== {r[7:0], c, v}) begin
        fails++;
        $display("FAIL bp hold %0d: out_valid=%b in_ready=%b result=%h/%b/%b, required 1 0 %h/%b/%b", i,
                 if8.out_valid, if8.in_ready, if8.result, if8.cout, if8.ovf, r[7:0], c, v);
      end
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    checks++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp release: out_valid=%b in_ready=%b, required 0 1", if8.out_valid, if8.in_ready);
    end
  endtask

  task automatic test_reset_mid_add;
    if8.a = 8'hFF; if8.b = 8'h01; if8.sub = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checks++;
    if ({if8.result, if8.cout, if8.ovf, if8.out_valid, if8.busy, if8.in_ready} !== {8'h00, 5'b00001} ||
        {if84.result, if84.cout, if84.ovf, if84.out_valid, if84.busy, if84.in_ready} !== {8'h00, 5'b00001}) begin
      fails++;
      $display("FAIL mid-add reset: d1 %h%b%b%b%b%b d4 %h%b%b%b%b%b, required zeros with in_ready=1",
               if8.result, if8.cout, if8.ovf, if8.out_valid, if8.busy, if8.in_ready,
               if84.result, if84.cout, if84.ovf, if84.out_valid, if84.busy, if84.in_ready);
    end
    rst = 1'b0;
    op8(8'h00, 8'h00, 1'b0, "after_reset_zero");
    op8(8'h10, 8'h20, 1'b1, "after_reset_sub");
  endtask

  task automatic test_width16;
    op16(16'h1234, 16'h0FCD, 1'b0, "w16_1234_0fcd");
    op16(16'h8000, 16'h0001, 1'b1, "w16_sub_8000_1");
    for (int k = 0; k < 10; k++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
    end
  endtask

  task automatic test_back_to_back;
    longint r;
    bit c, v;
    int lat;
    logic [15:0] xa, xb;
    logic xs;
    if16.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      xa = 16'($urandom); xb = 16'($urandom); xs = 1'($urandom);
      model(16, longint'(xa), longint'(xb), xs, r, c, v);
      if16.a = xa; if16.b = xb; if16.sub = xs; if16.in_valid = 1'b1;
      checks++;
      if (if16.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b %0d ready: in_ready=%b, required 1", k, if16.in_ready);
      end
      @(posedge clk); #1;
      if16.a = ~xa; if16.b = ~xb; if16.sub = ~xs;
      lat = 0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
        @(posedge clk); #1;
        if (if16.out_valid === 1'b1) lat = n;
      end
      checks++;
      if (lat != 8 || {if16.result, if16.cout, if16.ovf} !== {r[15:0], c, v}) begin
        fails++;
        $display("FAIL b2b %0d: latency %0d result %h/%b/%b, required 8 %h/%b/%b", k, lat,
                 if16.result, if16.cout, if16.ovf, r[15:0], c, v);
      end
      @(posedge clk); #1;
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b0;
  endtask

  initial begin
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.sub = 1'b0; if8.out_ready = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.sub = 1'b0; if16.out_ready = 1'b0;
    test_reset();
    test_add_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid_add();
    test_width16();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end
endmodule
